cam_capture_ctrl: RTL and testbench

//  Consumes the camera-control register fields (trigger_capture_frame, continuous_capture_frame,
//  cam_dma_init_done) and gates whole frames from the sensor interface into the camera DMA.

---
 rtl/cam_capture_ctrl_pkg.sv | 22 ++
 rtl/cam_capture_ctrl_fps_meter.sv | 37 +++
 rtl/cam_capture_ctrl.sv | 90 +++++++++
 tb/tb_cam_capture_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_ctrl_pkg.sv
// Shared definitions for the camera capture controller: FSM state encoding
// and packing of the debug status word read through the APB3 register block.
package cam_capture_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_UNUSED  = 2'd3
  } cap_state_e;

  localparam logic [7:0] DROP_MAX = 8'hFF;

  // Status word: {cap_cnt[15:0], drop_cnt[7:0], 5'b0, vs_q, state[1:0]}
  function automatic logic [31:0] pack_status(input logic [15:0] cap,
                                              input logic [7:0]  drop,
                                              input logic        vs,
                                              input logic [1:0]  st);
    return {cap, drop, 5'b0, vs, st};
  endfunction

endpackage

// File: rtl/cam_capture_ctrl_fps_meter.sv
// Counts sensor frame starts over a fixed window of CLK_FREQ_HZ clocks and
// publishes the count of the last complete window.
module fps_meter #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sof,
  output logic [31:0] frames_per_second
);

  localparam int unsigned       WIN_W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(CLK_FREQ_HZ - 1);

  logic [WIN_W-1:0] win_cnt;
  logic [31:0]      fps_acc;
  logic [31:0]      acc_inc;

  // A frame start on the terminal cycle still belongs to the closing window.
  assign acc_inc = (sof && (fps_acc != '1)) ? fps_acc + 32'd1 : fps_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_cnt           <= '0;
      fps_acc           <= '0;
      frames_per_second <= '0;
    end else if (win_cnt == WIN_LAST) begin
      win_cnt           <= '0;
      fps_acc           <= '0;
      frames_per_second <= acc_inc;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
      fps_acc <= acc_inc;
    end
  end

endmodule

// File: rtl/cam_capture_ctrl.sv
// Gates whole sensor frames into the camera DMA under register control and
// reports capture/drop counts and frame rate for the register block.
module cam_capture_ctrl
  import cam_capture_defs::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter bit          VSYNC_POL   = 1'b1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cam_vsync,
  input  logic        trigger_capture_frame,
  input  logic        continuous_capture_frame,
  input  logic        cam_dma_init_done,
  output logic        capture_en,
  output logic        frame_done,
  output logic [31:0] frames_per_second,
  output logic [31:0] debug_cam_dma_status
);

  cap_state_e           state, state_next;
  logic                 vs_act, vs_q, trig_q;
  logic                 sof, eof, trig_rise;
  logic                 done_next;
  logic [CNT_WIDTH-1:0] cap_cnt;
  logic [7:0]           drop_cnt;

  assign vs_act    = cam_vsync ^ ~VSYNC_POL;
  assign sof       = vs_act & ~vs_q;
  assign eof       = ~vs_act & vs_q;
  assign trig_rise = trigger_capture_frame & ~trig_q;

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cam_dma_init_done && (trig_rise || continuous_capture_frame))
          state_next = ST_ARMED;
      end
      ST_ARMED: begin
        if (!cam_dma_init_done) state_next = ST_IDLE;
        else if (sof)           state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Losing DMA readiness mid-frame is only acted on at the frame boundary.
        if (eof) begin
          done_next  = 1'b1;
          state_next = (continuous_capture_frame && cam_dma_init_done) ? ST_ARMED : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      vs_q       <= 1'b0;
      trig_q     <= 1'b0;
      capture_en <= 1'b0;
      frame_done <= 1'b0;
      cap_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_next;
      vs_q       <= vs_act;
      trig_q     <= trigger_capture_frame;
      capture_en <= (state_next == ST_CAPTURE);
      frame_done <= done_next;
      if (done_next)
        cap_cnt <= cap_cnt + CNT_WIDTH'(1);
      if ((state == ST_IDLE) && sof && continuous_capture_frame && (drop_cnt != DROP_MAX))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  fps_meter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_fps_meter (
    .clk              (clk),
    .resetn           (resetn),
    .sof              (sof),
    .frames_per_second(frames_per_second)
  );

  assign debug_cam_dma_status = pack_status(16'(cap_cnt), drop_cnt, vs_q, state);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Scenario bench for cam_capture_ctrl: expected captured frames are queued as
// stimulus is driven and retired by a monitor on each frame_done pulse.
module tb_cam_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cam_vsync;
  logic        trigger_capture_frame;
  logic        continuous_capture_frame;
  logic        cam_dma_init_done;
  logic        capture_en;
  logic        frame_done;
  logic [31:0] frames_per_second;
  logic [31:0] debug_cam_dma_status;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int unsigned run_len = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  cam_capture_ctrl #(
    .CLK_FREQ_HZ(100),
    .VSYNC_POL  (1'b1),
    .CNT_WIDTH  (16)
  ) dut (
    .clk                     (clk),
    .resetn                  (resetn),
    .cam_vsync               (cam_vsync),
    .trigger_capture_frame   (trigger_capture_frame),
    .continuous_capture_frame(continuous_capture_frame),
    .cam_dma_init_done       (cam_dma_init_done),
    .capture_en              (capture_en),
    .frame_done              (frame_done),
    .frames_per_second       (frames_per_second),
    .debug_cam_dma_status    (debug_cam_dma_status)
  );

  // Monitor: every frame_done must match a queued expectation and close a
  // capture window of exactly one full active period (20 cycles).
  always @(negedge clk) begin
    if (!resetn) begin
      run_len = 0;
    end else begin
      if (frame_done) begin
        done_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame_done: got frame_done=1 cap_cnt=%0d, expected no frame", debug_cam_dma_status[31:16]);
        end else begin
          automatic logic [15:0] exp_cap = exp_q.pop_front();
          if (debug_cam_dma_status[31:16] !== exp_cap) begin
            failures++;
            $display("FAIL cap_cnt_at_done: got %0d expected %0d", debug_cam_dma_status[31:16], exp_cap);
          end
        end
        checks++;
        if (run_len !== 20) begin
          failures++;
          $display("FAIL capture_window_len: got %0d expected 20", run_len);
        end
      end
      if (capture_en) run_len++;
      else            run_len = 0;
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    cam_vsync = 1'b1;
    step(20);
    cam_vsync = 1'b0;
    step(5);
  endtask

  task automatic do_reset();
    resetn                   = 1'b0;
    cam_vsync                = 1'b0;
    trigger_capture_frame    = 1'b0;
    continuous_capture_frame = 1'b0;
    cam_dma_init_done        = 1'b0;
    exp_q.delete();
    step(2);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(1);
    checks++;
    if (capture_en !== 1'b0) begin failures++; $display("FAIL reset_capture_en: got %b expected 0", capture_en); end
    checks++;
    if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++;
    if (frames_per_second !== 32'd0) begin failures++; $display("FAIL reset_fps: got %0d expected 0", frames_per_second); end
    checks++;
    if (debug_cam_dma_status !== 32'd0) begin failures++; $display("FAIL reset_status: got %h expected 00000000", debug_cam_dma_status); end
  endtask

  task automatic test_single_shot();
    int d0;
    do_reset();
    cam_dma_init_done = 1'b1;
    d0 = done_seen;
    // Trigger arrives while a frame is already active: that frame is skipped.
    cam_vsync = 1'b1;
    step(5);
    trigger_capture_frame = 1'b1;
    step(2);
    trigger_capture_frame = 1'b0;
    step(13);
    checks++;
    if (capture_en !== 1'b0) begin failures++; $display("FAIL single_inprogress_capture_en: got %b expected 0", capture_en); end
    cam_vsync = 1'b0;
    step(5);
    checks++;
    if (debug_cam_dma_status[1:0] !== 2'd1) begin failures++; $display("FAIL single_armed_state: got %0d expected 1", debug_cam_dma_status[1:0]); end
    exp_q.push_back(16'd1);
    cam_vsync = 1'b1;
    step(1);
    checks++;
    if (capture_en !== 1'b1) begin failures++; $display("FAIL single_capture_start: got %b expected 1", capture_en); end
    step(19);
    cam_vsync = 1'b0;
    step(5);
    frame();
    checks++;
    if (done_seen - d0 !== 1) begin failures++; $display("FAIL single_done_count: got %0d expected 1", done_seen - d0); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL single_pending: got %0d frames missing expected 0", exp_q.size()); end
    checks++;
    if (debug_cam_dma_status !== {16'd1, 8'd0, 5'd0, 1'b0, 2'd0}) begin
      failures++; $display("FAIL single_final_status: got %h expected 00010000", debug_cam_dma_status);
    end
  endtask

  task automatic test_continuous();
    int d0;
    do_reset();
    cam_dma_init_done        = 1'b1;
    continuous_capture_frame = 1'b1;
    step(1);
    d0 = done_seen;
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    repeat (8) frame();
    checks++;
    if (done_seen - d0 !== 8) begin failures++; $display("FAIL cont_done_count: got %0d expected 8", done_seen - d0); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL cont_pending: got %0d frames missing expected 0", exp_q.size()); end
    checks++;
    if (debug_cam_dma_status[1:0] !== 2'd1) begin failures++; $display("FAIL cont_rearmed_state: got %0d expected 1", debug_cam_dma_status[1:0]); end
    checks++;
    if (debug_cam_dma_status[15:8] !== 8'd0) begin failures++; $display("FAIL cont_drop_cnt: got %0d expected 0", debug_cam_dma_status[15:8]); end
  endtask

  task automatic test_fps();
    do_reset();
    // Frame starts land on window cycles 25, 50, 75, 100 and 125..200.
    step(24);
    repeat (3) frame();
    checks++;
    if (frames_per_second !== 32'd0) begin failures++; $display("FAIL fps_first_window_pending: got %0d expected 0", frames_per_second); end
    cam_vsync = 1'b1;
    step(1);
    checks++;
    if (frames_per_second !== 32'd4) begin failures++; $display("FAIL fps_window1_terminal_sof: got %0d expected 4", frames_per_second); end
    step(19);
    cam_vsync = 1'b0;
    step(5);
    repeat (3) frame();
    cam_vsync = 1'b1;
    step(1);
    checks++;
    if (frames_per_second !== 32'd4) begin failures++; $display("FAIL fps_window2: got %0d expected 4", frames_per_second); end
    step(19);
    cam_vsync = 1'b0;
    step(81);
    checks++;
    if (frames_per_second !== 32'd0) begin failures++; $display("FAIL fps_window3_empty: got %0d expected 0", frames_per_second); end
  endtask

  task automatic test_dma_drop();
    do_reset();
    cam_dma_init_done        = 1'b1;
    continuous_capture_frame = 1'b1;
    step(1);
    exp_q.push_back(16'd1);
    cam_vsync = 1'b1;
    step(10);
    cam_dma_init_done = 1'b0;
    step(5);
    checks++;
    if (capture_en !== 1'b1) begin failures++; $display("FAIL dma_drop_no_truncate: got %b expected 1", capture_en); end
    step(5);
    cam_vsync = 1'b0;
    step(5);
    checks++;
    if (debug_cam_dma_status[1:0] !== 2'd0) begin failures++; $display("FAIL dma_drop_idle_state: got %0d expected 0", debug_cam_dma_status[1:0]); end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL dma_drop_pending: got %0d frames missing expected 0", exp_q.size()); end
    repeat (3) frame();
    checks++;
    if (debug_cam_dma_status[15:8] !== 8'd3) begin failures++; $display("FAIL drop_cnt_three: got %0d expected 3", debug_cam_dma_status[15:8]); end
    repeat (260) begin
      cam_vsync = 1'b1;
      step(1);
      cam_vsync = 1'b0;
      step(1);
    end
    checks++;
    if (debug_cam_dma_status[15:8] !== 8'hFF) begin failures++; $display("FAIL drop_cnt_saturate: got %0d expected 255", debug_cam_dma_status[15:8]); end
    checks++;
    if (debug_cam_dma_status[31:16] !== 16'd1) begin failures++; $display("FAIL dma_drop_cap_cnt: got %0d expected 1", debug_cam_dma_status[31:16]); end
  endtask

  task automatic test_discarded_trigger();
    int d0;
    do_reset();
    d0 = done_seen;
    trigger_capture_frame = 1'b1;
    step(3);
    cam_dma_init_done = 1'b1;
    step(3);
    repeat (2) frame();
    trigger_capture_frame = 1'b0;
    step(1);
    checks++;
    if (done_seen - d0 !== 0) begin failures++; $display("FAIL discard_done_count: got %0d expected 0", done_seen - d0); end
    checks++;
    if (debug_cam_dma_status[1:0] !== 2'd0) begin failures++; $display("FAIL discard_state: got %0d expected 0", debug_cam_dma_status[1:0]); end
  endtask

  task automatic test_reset_mid_capture();
    do_reset();
    cam_dma_init_done     = 1'b1;
    trigger_capture_frame = 1'b1;
    step(1);
    trigger_capture_frame = 1'b0;
    cam_vsync = 1'b1;
    step(10);
    checks++;
    if (capture_en !== 1'b1) begin failures++; $display("FAIL midreset_precondition: got capture_en=%b expected 1", capture_en); end
    resetn = 1'b0;
    #2;
    checks++;
    if (capture_en !== 1'b0) begin failures++; $display("FAIL midreset_async_capture_en: got %b expected 0", capture_en); end
    checks++;
    if (debug_cam_dma_status !== 32'd0) begin failures++; $display("FAIL midreset_async_status: got %h expected 00000000", debug_cam_dma_status); end
    step(2);
    resetn = 1'b1;
    step(2);
    trigger_capture_frame = 1'b1;
    step(1);
    trigger_capture_frame = 1'b0;
    step(2);
    checks++;
    if (capture_en !== 1'b0) begin failures++; $display("FAIL midreset_no_resume_midframe: got %b expected 0", capture_en); end
    cam_vsync = 1'b0;
    step(5);
    exp_q.push_back(16'd1);
    frame();
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL midreset_pending: got %0d frames missing expected 0", exp_q.size()); end
  endtask

  initial begin
    resetn                   = 1'b0;
    cam_vsync                = 1'b0;
    trigger_capture_frame    = 1'b0;
    continuous_capture_frame = 1'b0;
    cam_dma_init_done        = 1'b0;
    test_reset();
    test_single_shot();
    test_continuous();
    test_fps();
    test_dma_drop();
    test_discarded_trigger();
    test_reset_mid_capture();
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
